// File: rtl/seq_detector_param.sv
// Serial pattern detector: compares the last N accepted bits against a
// programmable pattern, with Mealy/Moore output, overlap control and a saturating match counter.
module seq_detector_param #(
    parameter int             N        = 4,
    parameter logic [N-1:0]   PAT_INIT = 4'b0011,
    parameter int             CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             a,
    input  logic             load,
    input  logic [N-1:0]     pattern,
    input  logic             overlap,
    input  logic             moore,
    input  logic             clr_cnt,
    output logic             y,
    output logic [CNT_W-1:0] match_count,
    output logic             sat
);

    localparam int               FW       = $clog2(N);
    localparam logic [FW-1:0]    FILL_MAX = FW'(N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [N-1:0]     pat_q,  pat_d;
    logic [N-2:0]     hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             y_q;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             sat_q,  sat_d;

    logic [N-1:0]     window;
    logic             match_now;

    // Oldest bit sits at the MSB, so the incoming bit completes the window at bit 0.
    assign window    = {hist_q, a};
    assign match_now = en && !load && (fill_q == FILL_MAX) && (window == pat_q);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (load) begin
            pat_d  = pattern;
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            if (match_now && !overlap) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = window[N-2:0];
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + 1'b1;
                end
            end
        end
    end

    // A clear wins over a coincident match; sat rises as soon as the count reaches its ceiling.
    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clr_cnt) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (match_now) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            sat_d = sat_q | (cnt_d == CNT_MAX);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q  <= PAT_INIT;
            hist_q <= '0;
            fill_q <= '0;
            y_q    <= 1'b0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            y_q    <= match_now;
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
        end
    end

    assign y           = moore ? y_q : match_now;
    assign match_count = cnt_q;
    assign sat         = sat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param (N=4, CNT_W=2): the driver queues hand-computed
// expectations per cycle, and a negedge monitor pops and compares them.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset, en, a, load, overlap, moore, clr_cnt;
    logic [3:0] pattern;
    logic       y;
    logic [1:0] match_count;
    logic       sat;

    logic       ov_n, mo_n;
    logic [3:0] pat_n;

    typedef struct {
        string      name;
        logic       y;
        logic [1:0] cnt;
        logic       sat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    seq_detector_param #(.N(4), .PAT_INIT(4'b0011), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .en(en), .a(a), .load(load), .pattern(pattern),
        .overlap(overlap), .moore(moore), .clr_cnt(clr_cnt),
        .y(y), .match_count(match_count), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Drive one cycle of stimulus just after the rising edge and queue what the
    // outputs must show before the next rising edge.
    task automatic step(input string name, input logic e, input logic d, input logic ld,
                        input logic clr, input logic ey, input logic [1:0] ec, input logic es);
        exp_t x;
        @(posedge clk);
        #1;
        en = e; a = d; load = ld; clr_cnt = clr;
        overlap = ov_n; moore = mo_n; pattern = pat_n;
        x.name = name; x.y = ey; x.cnt = ec; x.sat = es;
        exp_q.push_back(x);
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check({x.name, ".y"},   32'(y),           32'(x.y));
            check({x.name, ".cnt"}, 32'(match_count), 32'(x.cnt));
            check({x.name, ".sat"}, 32'(sat),         32'(x.sat));
        end
    end

    // Assert reset between edges and check the outputs clear without a clock.
    task automatic pulse_reset(input string name);
        @(negedge clk);
        #2;
        en = 1'b1; a = 1'b1; load = 1'b0; clr_cnt = 1'b0;
        reset = 1'b0;
        #1;
        check({name, ".async.y"},   32'(y),           0);
        check({name, ".async.cnt"}, 32'(match_count), 0);
        check({name, ".async.sat"}, 32'(sat),         0);
        @(posedge clk);
        #1;
        check({name, ".held.y"},   32'(y),           0);
        check({name, ".held.cnt"}, 32'(match_count), 0);
        en = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; a = 1'b0; load = 1'b0; clr_cnt = 1'b0;
        overlap = 1'b1; moore = 1'b0; pattern = 4'b0000;
        ov_n = 1'b1; mo_n = 1'b0; pat_n = 4'b1011;
        #2;
        check("por.y",   32'(y),           0);
        check("por.cnt", 32'(match_count), 0);
        check("por.sat", 32'(sat),         0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Overlapping Mealy, stream 1011011
        step("s1.load", 0,0,1,0, 0,2'd0,0);
        step("s1.b1",   1,1,0,0, 0,2'd0,0);
        step("s1.b2",   1,0,0,0, 0,2'd0,0);
        step("s1.b3",   1,1,0,0, 0,2'd0,0);
        step("s1.b4",   1,1,0,0, 1,2'd0,0);
        step("s1.b5",   1,0,0,0, 0,2'd1,0);
        step("s1.b6",   1,1,0,0, 0,2'd1,0);
        step("s1.b7",   1,1,0,0, 1,2'd1,0);
        step("s1.idle", 0,0,0,0, 0,2'd2,0);

        // Non-overlapping: bit 7 must not match
        ov_n = 1'b0;
        step("s2.load", 0,0,1,1, 0,2'd2,0);
        step("s2.b1",   1,1,0,0, 0,2'd0,0);
        step("s2.b2",   1,0,0,0, 0,2'd0,0);
        step("s2.b3",   1,1,0,0, 0,2'd0,0);
        step("s2.b4",   1,1,0,0, 1,2'd0,0);
        step("s2.b5",   1,0,0,0, 0,2'd1,0);
        step("s2.b6",   1,1,0,0, 0,2'd1,0);
        step("s2.b7",   1,1,0,0, 0,2'd1,0);
        step("s2.idle", 0,0,0,0, 0,2'd1,0);

        // Moore: y one cycle after bits 4 and 7
        ov_n = 1'b1; mo_n = 1'b1;
        step("s3.load", 0,0,1,1, 0,2'd1,0);
        step("s3.b1",   1,1,0,0, 0,2'd0,0);
        step("s3.b2",   1,0,0,0, 0,2'd0,0);
        step("s3.b3",   1,1,0,0, 0,2'd0,0);
        step("s3.b4",   1,1,0,0, 0,2'd0,0);
        step("s3.b5",   1,0,0,0, 1,2'd1,0);
        step("s3.b6",   1,1,0,0, 0,2'd1,0);
        step("s3.b7",   1,1,0,0, 0,2'd1,0);
        step("s3.i1",   0,0,0,0, 1,2'd2,0);
        step("s3.i2",   0,0,0,0, 0,2'd2,0);

        // en gaps are ignored; a load in the gap wipes history
        mo_n = 1'b0;
        step("s4.load", 0,0,1,1, 0,2'd2,0);
        step("s4.b1",   1,1,0,0, 0,2'd0,0);
        step("s4.b2",   1,0,0,0, 0,2'd0,0);
        step("s4.g1",   0,1,0,0, 0,2'd0,0);
        step("s4.g2",   0,1,0,0, 0,2'd0,0);
        step("s4.g3",   0,1,0,0, 0,2'd0,0);
        step("s4.b3",   1,1,0,0, 0,2'd0,0);
        step("s4.b4",   1,1,0,0, 1,2'd0,0);
        step("s4.rl",   0,0,1,0, 0,2'd1,0);
        step("s4.c1",   1,1,0,0, 0,2'd1,0);
        step("s4.c2",   1,0,0,0, 0,2'd1,0);
        step("s4.cg1",  0,0,0,0, 0,2'd1,0);
        step("s4.cld",  1,1,1,0, 0,2'd1,0);
        step("s4.cg2",  0,0,0,0, 0,2'd1,0);
        step("s4.c3",   1,1,0,0, 0,2'd1,0);
        step("s4.c4",   1,1,0,0, 0,2'd1,0);
        step("s4.idle", 0,0,0,0, 0,2'd1,0);

        // Saturation with 1111, then clear racing a match
        pat_n = 4'b1111;
        step("s5.load", 0,0,1,1, 0,2'd1,0);
        step("s5.b1",   1,1,0,0, 0,2'd0,0);
        step("s5.b2",   1,1,0,0, 0,2'd0,0);
        step("s5.b3",   1,1,0,0, 0,2'd0,0);
        step("s5.b4",   1,1,0,0, 1,2'd0,0);
        step("s5.b5",   1,1,0,0, 1,2'd1,0);
        step("s5.b6",   1,1,0,0, 1,2'd2,0);
        step("s5.b7",   1,1,0,0, 1,2'd3,1);
        step("s5.b8",   1,1,0,0, 1,2'd3,1);
        step("s5.clr",  1,1,0,1, 1,2'd3,1);
        step("s5.idle", 0,0,0,0, 0,2'd0,0);
        step("s5.b9",   1,1,0,0, 1,2'd0,0);

        // Reset mid-sequence; afterwards the pattern is back to 0011
        pat_n = 4'b1011;
        step("s6.load", 0,0,1,0, 0,2'd1,0);
        step("s6.b1",   1,1,0,0, 0,2'd1,0);
        step("s6.b2",   1,0,0,0, 0,2'd1,0);
        step("s6.b3",   1,1,0,0, 0,2'd1,0);
        pulse_reset("s6.r1");
        step("s6.p1",   1,1,0,0, 0,2'd0,0);
        step("s6.p2",   1,0,0,0, 0,2'd0,0);
        step("s6.p3",   1,0,0,0, 0,2'd0,0);
        step("s6.p4",   1,1,0,0, 0,2'd0,0);
        step("s6.p5",   1,1,0,0, 1,2'd0,0);
        step("s6.q1",   1,0,0,0, 0,2'd1,0);
        step("s6.q2",   1,0,0,0, 0,2'd1,0);
        step("s6.q3",   1,1,0,0, 0,2'd1,0);
        pulse_reset("s6.r2");
        step("s6.r1b",  1,1,0,0, 0,2'd0,0);
        step("s6.rl",   0,0,1,0, 0,2'd0,0);
        step("s6.f1",   1,1,0,0, 0,2'd0,0);
        step("s6.f2",   1,0,0,0, 0,2'd0,0);
        step("s6.f3",   1,1,0,0, 0,2'd0,0);
        step("s6.f4",   1,1,0,0, 1,2'd0,0);
        step("s6.idle", 0,0,0,0, 0,2'd1,0);

        for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        check("drain.pending", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
